exu_alu_share_arb: RTL and testbench

//  Round-robin arbiter and scheduler for the shared ALU datapath. Sits between the
//  EXU requesters (regular ALU, BJP, AGU by default) and the single shared ALU

---
 rtl/exu_alu_share_arb.sv | 144 ++++++++++++++
 tb/tb_exu_alu_share_arb.sv | 289 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/exu_alu_share_arb.sv
// exu_alu_share_arb: round-robin arbiter/scheduler in front of the single shared ALU datapath.
//   Grants at most one requester per cycle, drives its op one-hot and operands to the datapath,
//   and registers the combinational datapath result into a one-entry response buffer.
//   A requester may lock the datapath across several beats.
// Ports:
//   clk, rst                    clock, synchronous active-high reset
//   req_valid/ready/lock        per-requester handshake and lock request
//   req_op/op1/op2              per-requester op one-hot and operands, slice i = [i*W +: W]
//   rsp_valid/ready             one-hot result valid to the owner, owner consume
//   rsp_res, rsp_id             registered result (broadcast) and its owner id
//   dp_op/op1/op2, dp_res       shared datapath drive and its combinational result
// Configuration:
//   E203_ALU_ARB_GATE_EN        defined: dp_op1/dp_op2 forced to zero when nothing is granted.
//                               undefined: they carry the next-candidate requester's operands.

`ifndef E203_XLEN
`define E203_XLEN 32
`endif

module exu_alu_share_arb #(
  parameter int unsigned NREQ = 3,
  parameter int unsigned XLEN = `E203_XLEN,
  parameter int unsigned OPW  = 11,
  parameter int unsigned IDW  = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NREQ-1:0]      req_valid,
  output logic [NREQ-1:0]      req_ready,
  input  logic [NREQ-1:0]      req_lock,
  input  logic [NREQ*OPW-1:0]  req_op,
  input  logic [NREQ*XLEN-1:0] req_op1,
  input  logic [NREQ*XLEN-1:0] req_op2,
  output logic [NREQ-1:0]      rsp_valid,
  input  logic [NREQ-1:0]      rsp_ready,
  output logic [XLEN-1:0]      rsp_res,
  output logic [IDW-1:0]       rsp_id,
  output logic [OPW-1:0]       dp_op,
  output logic [XLEN-1:0]      dp_op1,
  output logic [XLEN-1:0]      dp_op2,
  input  logic [XLEN-1:0]      dp_res
);

  typedef enum logic [0:0] {StIdle, StHold} state_e;

  state_e          state_q;
  logic [NREQ-1:0] rsp_valid_q;
  logic [XLEN-1:0] rsp_res_q;
  logic [IDW-1:0]  rsp_id_q;
  logic [IDW-1:0]  rr_ptr_q;
  logic [IDW-1:0]  lk_id_q;
  logic            locked_q;

  logic            can_issue;
  logic            gnt_vld;
  logic            issue;
  logic [IDW-1:0]  gnt_id;
  logic [IDW-1:0]  cand;
  logic [IDW-1:0]  sel_id;

  // Modular add for any NREQ; both inputs are below NREQ so one subtract suffices.
  function automatic logic [IDW-1:0] wrap_add(logic [IDW-1:0] base, int unsigned off);
    int unsigned s;
    s = 32'(base) + off;
    if (s >= NREQ) s = s - NREQ;
    return IDW'(s);
  endfunction

  // A slot is free when the buffer is empty or its owner drains it this very cycle.
  assign can_issue = (state_q == StIdle) | (rsp_valid_q[rsp_id_q] & rsp_ready[rsp_id_q]);

  always_comb begin
    gnt_vld = 1'b0;
    gnt_id  = rr_ptr_q;
    cand    = '0;
    if (locked_q) begin
      gnt_vld = req_valid[lk_id_q];
      gnt_id  = lk_id_q;
    end else begin
      for (int unsigned k = 0; k < NREQ; k++) begin
        cand = wrap_add(rr_ptr_q, k);
        if (!gnt_vld && req_valid[cand]) begin
          gnt_vld = 1'b1;
          gnt_id  = cand;
        end
      end
    end
  end

  assign issue = gnt_vld & can_issue & ~rst;

  always_comb begin
    for (int unsigned i = 0; i < NREQ; i++) begin
      req_ready[i] = issue & (gnt_id == IDW'(i));
    end
  end

  // With no grant, operands come from whoever would be considered next.
  assign sel_id = issue ? gnt_id : (locked_q ? lk_id_q : rr_ptr_q);

  always_comb begin
    dp_op = issue ? req_op[sel_id*OPW +: OPW] : '0;
`ifdef E203_ALU_ARB_GATE_EN
    dp_op1 = issue ? req_op1[sel_id*XLEN +: XLEN] : '0;
    dp_op2 = issue ? req_op2[sel_id*XLEN +: XLEN] : '0;
`else
    dp_op1 = req_op1[sel_id*XLEN +: XLEN];
    dp_op2 = req_op2[sel_id*XLEN +: XLEN];
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StIdle;
      rsp_valid_q <= '0;
      rsp_res_q   <= '0;
      rsp_id_q    <= '0;
      rr_ptr_q    <= '0;
      lk_id_q     <= '0;
      locked_q    <= 1'b0;
    end else if (issue) begin
      state_q     <= StHold;
      rsp_valid_q <= req_ready;
      rsp_res_q   <= dp_res;
      rsp_id_q    <= gnt_id;
      if (req_lock[gnt_id]) begin
        locked_q <= 1'b1;
        lk_id_q  <= gnt_id;
      end else begin
        // Only the lock owner can be accepted while locked, so this also releases it.
        locked_q <= 1'b0;
        rr_ptr_q <= wrap_add(gnt_id, 1);
      end
    end else if (state_q == StHold && can_issue) begin
      state_q     <= StIdle;
      rsp_valid_q <= '0;
    end
  end

  assign rsp_valid = rsp_valid_q;
  assign rsp_res   = rsp_res_q;
  assign rsp_id    = rsp_id_q;

endmodule

// File: tb/tb_exu_alu_share_arb.sv
module tb_exu_alu_share_arb;
  localparam int NREQ = 3;
  localparam int XLEN = 32;
  localparam int OPW  = 11;
  localparam int IDW  = 2;

  localparam logic [OPW-1:0] OP_ADD = 11'h001;
  localparam logic [OPW-1:0] OP_SUB = 11'h002;
  localparam logic [OPW-1:0] OP_XOR = 11'h004;
  localparam logic [OPW-1:0] OP_OR  = 11'h040;
  localparam logic [OPW-1:0] OP_LUI = 11'h400;

  logic                 clk = 1'b0;
  logic                 rst;
  logic [NREQ-1:0]      req_valid, req_ready, req_lock;
  logic [NREQ*OPW-1:0]  req_op;
  logic [NREQ*XLEN-1:0] req_op1, req_op2;
  logic [NREQ-1:0]      rsp_valid, rsp_ready;
  logic [XLEN-1:0]      rsp_res;
  logic [IDW-1:0]       rsp_id;
  logic [OPW-1:0]       dp_op;
  logic [XLEN-1:0]      dp_op1, dp_op2, dp_res;

  always #5 clk = ~clk;

  exu_alu_share_arb #(.NREQ(NREQ), .XLEN(XLEN), .OPW(OPW), .IDW(IDW)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_lock(req_lock),
    .req_op(req_op), .req_op1(req_op1), .req_op2(req_op2),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_res(rsp_res), .rsp_id(rsp_id),
    .dp_op(dp_op), .dp_op1(dp_op1), .dp_op2(dp_op2), .dp_res(dp_res)
  );

  // Shared ALU datapath stand-in.
  function automatic logic [XLEN-1:0] alu(logic [OPW-1:0] op, logic [XLEN-1:0] a,
                                          logic [XLEN-1:0] b);
    case (op)
      11'h001: return a + b;
      11'h002: return a - b;
      11'h004: return a ^ b;
      11'h008: return a << b[4:0];
      11'h010: return a >> b[4:0];
      11'h020: return XLEN'($signed(a) >>> b[4:0]);
      11'h040: return a | b;
      11'h080: return a & b;
      11'h100: return XLEN'($signed(a) < $signed(b));
      11'h200: return XLEN'(a < b);
      11'h400: return b;
      default: return '0;
    endcase
  endfunction

  assign dp_res = alu(dp_op, dp_op1, dp_op2);

  int errors = 0;
  int checks = 0;
  bit chk_en = 1'b0;
  int grants[$];

  task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Abstract model: buffer occupancy, owner, pointer and lock as plain integers.
  int              m_busy, m_id, m_ptr, m_lk, m_lkid;
  logic [XLEN-1:0] m_res;
  int              c_g, c_sel, c_dg;
  logic            c_can;
  logic [NREQ-1:0] c_rdy, c_rv;
  logic [OPW-1:0]  c_op;

  always @(negedge clk) begin
    c_can = (m_busy == 0) || rsp_ready[m_id];
    c_g = -1;
    if (m_lk != 0) begin
      if (req_valid[m_lkid]) c_g = m_lkid;
    end else begin
      for (int k = NREQ - 1; k >= 0; k--) begin
        if (req_valid[(m_ptr + k) % NREQ]) c_g = (m_ptr + k) % NREQ;
      end
    end
    if (!c_can || rst) c_g = -1;
    c_rdy = '0;
    c_op  = '0;
    if (c_g >= 0) begin
      c_rdy[c_g] = 1'b1;
      c_op = req_op[c_g*OPW +: OPW];
    end
    c_rv = '0;
    if (m_busy != 0) c_rv[m_id] = 1'b1;
    c_sel = (c_g >= 0) ? c_g : ((m_lk != 0) ? m_lkid : m_ptr);

    if (chk_en) begin
      chk("req_ready", req_ready, c_rdy);
      chk("rsp_valid", rsp_valid, c_rv);
      chk("rsp_res", rsp_res, m_res);
      chk("rsp_id", rsp_id, m_id);
      chk("dp_op", dp_op, c_op);
`ifdef E203_ALU_ARB_GATE_EN
      chk("dp_op1", dp_op1, (c_g >= 0) ? req_op1[c_sel*XLEN +: XLEN] : '0);
      chk("dp_op2", dp_op2, (c_g >= 0) ? req_op2[c_sel*XLEN +: XLEN] : '0);
`else
      chk("dp_op1", dp_op1, req_op1[c_sel*XLEN +: XLEN]);
      chk("dp_op2", dp_op2, req_op2[c_sel*XLEN +: XLEN]);
`endif
      c_dg = -1;
      for (int i = 0; i < NREQ; i++) if (req_ready[i]) c_dg = i;
      if (c_dg >= 0) grants.push_back(c_dg);
    end

    if (rst) begin
      m_busy = 0; m_id = 0; m_ptr = 0; m_lk = 0; m_lkid = 0; m_res = '0;
    end else if (c_g >= 0) begin
      m_busy = 1;
      m_id   = c_g;
      m_res  = alu(req_op[c_g*OPW +: OPW], req_op1[c_g*XLEN +: XLEN],
                   req_op2[c_g*XLEN +: XLEN]);
      if (req_lock[c_g]) begin
        m_lk = 1; m_lkid = c_g;
      end else begin
        m_lk = 0; m_ptr = (c_g + 1) % NREQ;
      end
    end else if (m_busy != 0 && rsp_ready[m_id]) begin
      m_busy = 0;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic peek();
    @(negedge clk);
    #1;
  endtask

  task automatic set_req(int i, logic [OPW-1:0] op, logic [XLEN-1:0] a, logic [XLEN-1:0] b);
    req_op[i*OPW +: OPW]    = op;
    req_op1[i*XLEN +: XLEN] = a;
    req_op2[i*XLEN +: XLEN] = b;
  endtask

  task automatic chk_grants(string name, int exp[$]);
    chk({name, "_count"}, grants.size(), exp.size());
    for (int i = 0; i < exp.size() && i < grants.size(); i++) chk(name, grants[i], exp[i]);
  endtask

  initial begin
    rst = 1'b1; req_valid = '0; req_lock = '0; rsp_ready = '0;
    req_op = '0; req_op1 = '0; req_op2 = '0;
    tick();
    chk_en = 1'b1;
    req_valid = '1;
    peek();
    chk("rst_req_ready", req_ready, 0);
    chk("rst_rsp_valid", rsp_valid, 0);
    tick();
    rst = 1'b0; req_valid = '0;

    // Single request: 5 + 7.
    set_req(0, OP_ADD, 5, 7);
    rsp_ready = '1;
    req_valid = 3'b001;
    peek();
    chk("t1_req_ready", req_ready, 3'b001);
    chk("t1_dp_op", dp_op, OP_ADD);
    tick();
    req_valid = '0;
    peek();
    chk("t1_rsp_valid", rsp_valid, 3'b001);
    chk("t1_rsp_res", rsp_res, 12);
    chk("t1_rsp_id", rsp_id, 0);
    tick();

    // Round-robin from a clean pointer.
    rst = 1'b1;
    tick();
    rst = 1'b0;
    set_req(1, OP_SUB, 20, 3);
    set_req(2, OP_XOR, 32'hf0, 32'h3c);
    req_valid = 3'b111;
    grants.delete();
    repeat (6) tick();
    req_valid = '0;
    peek();
    chk("t2_last_id", rsp_id, 2);
    chk("t2_last_res", rsp_res, 32'hcc);
    tick();
    chk_grants("t2_grant", '{0, 1, 2, 0, 1, 2});

    // Backpressure; non-owner rsp_ready must be ignored.
    set_req(0, OP_ADD, 1, 2);
    req_valid = 3'b001;
    rsp_ready = '0;
    tick();
    req_valid = 3'b010;
    for (int k = 0; k < 3; k++) begin
      rsp_ready = (k == 2) ? 3'b010 : 3'b000;
      peek();
      chk("t3_stall_ready", req_ready, 0);
      chk("t3_stall_res", rsp_res, 3);
      tick();
    end
    rsp_ready = 3'b001;
    peek();
    chk("t3_refill_ready", req_ready, 3'b010);
    tick();
    req_valid = '0;
    rsp_ready = '1;
    peek();
    chk("t3_rsp_res", rsp_res, 17);
    chk("t3_rsp_id", rsp_id, 1);
    tick();

    // Lock: pointer sits at 2 here.
    set_req(0, OP_OR, 32'h0f, 32'h30);
    set_req(2, OP_LUI, 0, 32'h12345000);
    req_valid = 3'b101;
    req_lock  = 3'b100;
    grants.delete();
    tick();
    tick();
    req_lock = '0;
    tick();
    tick();
    req_valid = '0;
    peek();
    chk("t4_or_res", rsp_res, 32'h3f);
    tick();
    chk_grants("t4_grant", '{2, 2, 2, 0});

    // Lock persists when the owner goes quiet; reset clears it.
    set_req(1, OP_ADD, 100, 1);
    req_valid = 3'b010;
    req_lock  = 3'b010;
    tick();
    req_valid = 3'b001;
    req_lock  = '0;
    peek();
    chk("t5_lock_stall_drain", req_ready, 0);
    tick();
    peek();
    chk("t5_lock_stall_idle", req_ready, 0);
    chk("t5_idle_rsp_valid", rsp_valid, 0);
    tick();
    req_valid = 3'b010;
    req_lock  = 3'b010;
    rsp_ready = '0;
    tick();
    rst = 1'b1;
    req_valid = '0;
    tick();
    rst = 1'b0;
    req_lock  = '0;
    req_valid = 3'b111;
    peek();
    chk("t5_post_rst_rsp_valid", rsp_valid, 0);
    chk("t5_post_rst_ready", req_ready, 3'b001);
    tick();
    req_valid = '0;
    rsp_ready = '1;
    tick();
    tick();

    // Idle datapath drive; pointer is 1 now.
    set_req(0, OP_ADD, 32'h11, 32'h44);
    set_req(1, OP_ADD, 32'h22, 32'h55);
    set_req(2, OP_ADD, 32'h33, 32'h66);
    peek();
    chk("t6_dp_op", dp_op, 0);
`ifdef E203_ALU_ARB_GATE_EN
    chk("t6_dp_op1", dp_op1, 0);
    chk("t6_dp_op2", dp_op2, 0);
`else
    chk("t6_dp_op1", dp_op1, 32'h22);
    chk("t6_dp_op2", dp_op2, 32'h55);
`endif
    tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
